// File: rtl/derand_pkg.sv
// Shared definitions for the PRBS 1+x^14+x^15 randomizer/derandomizer pair.
// Stage i of the LFSR lives in state bit i-1.
package derand_pkg;

  localparam int PRBS_ORDER = 15;
  localparam int TAP_A      = 14;
  localparam int TAP_B      = 15;

  localparam logic [PRBS_ORDER-1:0] DEFAULT_SEED = 15'h00A9;

  // Randomized reference block, transmitted MSB first
  localparam logic [95:0] REF_IN = 96'h558AC4A53A1724E163AC2BF9;

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic prbs_key(input logic [PRBS_ORDER-1:0] s);
    return s[TAP_A-1] ^ s[TAP_B-1];
  endfunction

  // The key bit enters stage 1 and every other stage takes its predecessor
  function automatic logic [PRBS_ORDER-1:0] prbs_step(input logic [PRBS_ORDER-1:0] s);
    return {s[PRBS_ORDER-2:0], prbs_key(s)};
  endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// PRBS15 keystream generator; key is the bit for the current state.
// load forces SEED, advance steps once, both together give SEED stepped once.
module prbs15_lfsr
  import derand_pkg::*;
#(
  parameter logic [PRBS_ORDER-1:0] SEED = DEFAULT_SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic advance,
  output logic key
);

  logic [PRBS_ORDER-1:0] state;

  assign key = prbs_key(state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (load && advance) begin
      state <= prbs_step(SEED);
    end else if (load) begin
      state <= SEED;
    end else if (advance) begin
      state <= prbs_step(state);
    end
  end

endmodule

// File: rtl/block_derandomizer.sv
// Block-framed PRBS15 derandomizer: restarts the keystream at every in_sof
// and presents each accepted bit one cycle later with block framing flags.
module block_derandomizer
  import derand_pkg::*;
#(
  parameter int                    BLOCK_LEN = 96,
  parameter int                    CNT_W     = 7,
  parameter logic [PRBS_ORDER-1:0] SEED      = DEFAULT_SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_sof,
  output logic out_valid,
  output logic out_bit,
  output logic out_first,
  output logic out_last,
  output logic sof_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);
  localparam logic             SINGLE   = (BLOCK_LEN == 1);
  localparam logic             SEED_KEY = prbs_key(SEED);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lfsr_key;
  logic             key;
  logic             start;
  logic             normal;
  logic             last;
  logic             accept;
  logic             lfsr_load;
  logic             lfsr_adv;

  assign start  = in_valid & in_sof;
  assign normal = in_valid & ~in_sof & (state == ACTIVE);
  assign last   = normal & (cnt == LAST_CNT);
  assign accept = start | normal;

  // A new block always uses the seed's key, even when it aborts a partial block
  assign key       = start ? SEED_KEY : lfsr_key;
  assign lfsr_load = start | last;
  assign lfsr_adv  = (start & ~SINGLE) | (normal & ~last);

  prbs15_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load   (lfsr_load),
    .advance(lfsr_adv),
    .key    (lfsr_key)
  );

  // Framing FSM, bit counter and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      out_valid <= accept;
      out_bit   <= accept & (in_bit ^ key);
      out_first <= start;
      out_last  <= last | (start & SINGLE);
      sof_err   <= start & (state == ACTIVE);
      if (start) begin
        state <= SINGLE ? IDLE : ACTIVE;
        cnt   <= SINGLE ? '0 : CNT_W'(1);
      end else if (last) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (normal) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_block_derandomizer.sv
// Self-checking bench for block_derandomizer: a hand-derived vector table
// followed by scoreboarded block sequences checked against a keystream model.
module tb_block_derandomizer;

  localparam int BL = 96;

  logic clk = 1'b0;
  logic reset, in_valid, in_bit, in_sof;
  logic out_valid, out_bit, out_first, out_last, sof_err;

  always #5 clk = ~clk;

  block_derandomizer #(
    .BLOCK_LEN(BL),
    .CNT_W    (7),
    .SEED     (15'h00A9)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_sof   (in_sof),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .out_first(out_first),
    .out_last (out_last),
    .sof_err  (sof_err)
  );

  typedef struct packed {
    logic valid;
    logic b;
    logic first;
    logic last;
    logic err;
  } obs_t;

  typedef struct {
    logic r;
    logic v;
    logic b;
    logic s;
    obs_t e;
  } vec_t;

  obs_t        sb_q[$];
  vec_t        tbl[17];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        ks[0:BL-1];
  logic        h[0:BL+14];
  logic [14:0] seed_v;
  logic [BL-1:0] ref_in, got_word, exp_word;
  bit          m_active;
  int          m_pos;
  int          cap_pos;
  int          n_first, n_last, n_err, n_valid;

  // Reference model of the block framing on top of the generated keystream
  function automatic obs_t model(input logic r, input logic v, input logic b, input logic s);
    obs_t e = '0;
    if (r) begin
      m_active = 1'b0;
      m_pos    = 0;
      return e;
    end
    if (!v) return e;
    if (s) begin
      e.valid  = 1'b1;
      e.b      = b ^ ks[0];
      e.first  = 1'b1;
      e.err    = m_active;
      e.last   = (BL == 1);
      m_active = (BL != 1);
      m_pos    = 1;
    end else if (m_active) begin
      e.valid = 1'b1;
      e.b     = b ^ ks[m_pos];
      e.last  = (m_pos == BL - 1);
      if (e.last) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else begin
        m_pos++;
      end
    end
    return e;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: valid/bit/first/last/err got %b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic check_word(input string name);
    n_checks++;
    if (got_word !== exp_word) begin
      n_fail++;
      $display("FAIL %s: stream got %h required %h", name, got_word, exp_word);
    end
  endtask

  task automatic clear_counts();
    n_first = 0;
    n_last  = 0;
    n_err   = 0;
    n_valid = 0;
  endtask

  task automatic sample_outputs();
    if (out_valid === 1'b1) begin
      if (out_first === 1'b1) begin
        cap_pos  = 0;
        got_word = 'x;
      end
      if (cap_pos < BL) got_word[BL-1-cap_pos] = out_bit;
      cap_pos++;
      n_valid++;
    end
    if (out_first === 1'b1) n_first++;
    if (out_last === 1'b1) n_last++;
    if (sof_err === 1'b1) n_err++;
  endtask

  // One clock: drive, push expectation, sample after the edge, pop and compare
  task automatic cycle(input string name, input logic r, input logic v, input logic b,
                       input logic s);
    obs_t got, exp;
    reset    = r;
    in_valid = v;
    in_bit   = b;
    in_sof   = s;
    sb_q.push_back(model(r, v, b, s));
    @(posedge clk);
    #1;
    got = '{out_valid, out_bit, out_first, out_last, sof_err};
    exp = sb_q.pop_front();
    check_obs(name, got, exp);
    sample_outputs();
  endtask

  task automatic send_block(input string name, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps && (i % 3 == 2)) cycle({name, "_gap"}, 1'b0, 1'b0, 1'($urandom), 1'b1);
      cycle(name, 1'b0, 1'b1, ref_in[BL-1-i], i == 0);
    end
  endtask

  task automatic idle_bits(input string name, input int count);
    for (int i = 0; i < count; i++) cycle(name, 1'b0, 1'b1, 1'($urandom), 1'b0);
  endtask

  initial begin
    seed_v = 15'h00A9;
    ref_in = 96'h558AC4A53A1724E163AC2BF9;
    for (int i = 1; i <= 15; i++) h[15-i] = seed_v[i-1];
    for (int t = 0; t < BL; t++) begin
      h[t+15] = h[t+1] ^ h[t];
      ks[t]   = h[t+15];
    end
    for (int t = 0; t < BL; t++) exp_word[BL-1-t] = ref_in[BL-1-t] ^ ks[t];
    m_active = 1'b0;
    m_pos    = 0;
    cap_pos  = 0;
    got_word = '0;
    clear_counts();

    // Hand-derived vectors; the keystream from this seed starts 0,0,0,0,0,0,1,1
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b00000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b00000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b00000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b11100};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11000};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b11101};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b11000};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b10000};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b00000};

    for (int i = 0; i < 17; i++) begin
      obs_t got;
      obs_t unused_e;
      reset    = tbl[i].r;
      in_valid = tbl[i].v;
      in_bit   = tbl[i].b;
      in_sof   = tbl[i].s;
      unused_e = model(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].s);
      @(posedge clk);
      #1;
      got = '{out_valid, out_bit, out_first, out_last, sof_err};
      check_obs($sformatf("table_%0d", i), got, tbl[i].e);
    end

    // Contiguous block
    clear_counts();
    send_block("contig", BL, 1'b0);
    check_word("contig_stream");
    check_int("contig_first_count", n_first, 1);
    check_int("contig_last_count", n_last, 1);
    check_int("contig_valid_count", n_valid, BL);
    cycle("contig_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Same block with a stall before every third bit
    clear_counts();
    send_block("gaps", BL, 1'b1);
    check_word("gaps_stream");
    check_int("gaps_valid_count", n_valid, BL);
    check_int("gaps_last_count", n_last, 1);

    // Back-to-back blocks
    clear_counts();
    send_block("b2b_a", BL, 1'b0);
    check_word("b2b_a_stream");
    send_block("b2b_b", BL, 1'b0);
    check_word("b2b_b_stream");
    check_int("b2b_err_count", n_err, 0);
    check_int("b2b_last_count", n_last, 2);

    // Abort at bit 40 by a fresh in_sof, then stray bits while idle
    clear_counts();
    send_block("abort_part", 40, 1'b0);
    send_block("abort_new", BL, 1'b0);
    check_word("abort_stream");
    check_int("abort_err_count", n_err, 1);
    check_int("abort_last_count", n_last, 1);
    check_int("abort_first_count", n_first, 2);
    clear_counts();
    idle_bits("idle_drop", 5);
    check_int("idle_drop_valid_count", n_valid, 0);

    // Reset part-way through a block
    clear_counts();
    send_block("rst_part", 50, 1'b0);
    cycle("rst_mid", 1'b1, 1'b1, 1'b1, 1'b1);
    idle_bits("rst_drop", 3);
    send_block("rst_new", BL, 1'b0);
    check_word("rst_stream");
    check_int("rst_last_count", n_last, 1);
    check_int("rst_err_count", n_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
